gain_ramp_controller: RTL and testbench

- Sequencer for the stereo AXIS volume-multiplier datapath.
- Turns the switch setting and a mute input into the multiplier gain consumed by the datapath.
- Moves the gain toward its target by at most one step per completed stereo packet, so switch changes, mute and power-up produce click-free ramps.
- Sits beside the multiplier: observes the sink-side last-word handshake and drives the gain word the multiplier latches.

---
 rtl/gain_ramp_controller_pkg.sv | 28 ++
 rtl/gain_ramp_controller_sync_bus.sv | 37 +++
 rtl/gain_ramp_controller.sv | 185 ++++++++++++++++++
 tb/tb_gain_ramp_controller.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/gain_ramp_controller_pkg.sv
// rtl/gain_ramp_controller_pkg.sv - shared constants, gain table and FSM states for the volume controller
//
// Purpose : types and constants shared by the gain ramp controller files.
// Contents: GAIN_ONE (unity gain), gain_table() (16-entry switch-to-gain map),
//           state_t (S_HOLD / S_RAMP / S_MUTED).
package vol_ctrl_pkg;

  localparam logic [24:0] GAIN_ONE = 25'h1000000;

  typedef enum logic [1:0] {
    S_HOLD  = 2'd0,
    S_RAMP  = 2'd1,
    S_MUTED = 2'd2
  } state_t;

  // Codes 0..14 are evenly spaced at 1/15 steps; code 15 is exact unity so the
  // top switch setting passes audio bit-exact.
  function automatic logic [24:0] gain_table(input logic [3:0] code);
    logic [24:0] v;
    if (code == 4'd15) begin
      v = GAIN_ONE;
    end else begin
      v = {21'd0, code} * 25'h111111;
    end
    return v;
  endfunction

endpackage

// File: rtl/gain_ramp_controller_sync_bus.sv
// rtl/gain_ramp_controller_sync_bus.sv - multi-flop synchronizer for slow asynchronous control levels
//
// Purpose : brings an asynchronous level bus into the clk domain.
// Ports   : clk    - destination clock
//           resetn - asynchronous active-low reset, clears every stage
//           i_data - asynchronous input bus
//           o_data - synchronized output (DEPTH cycles of latency)
// The bus inputs are quasi-static switch/mute levels, so per-bit synchronization
// is acceptable; a transient skew between bits settles within one cycle.
module sync_bus #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 3
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data
);

  logic [WIDTH-1:0] r_stage [DEPTH];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_stage[i] <= '0;
      end
    end else begin
      r_stage[0] <= i_data;
      for (int i = 1; i < DEPTH; i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  assign o_data = r_stage[DEPTH-1];

endmodule

// File: rtl/gain_ramp_controller.sv
// rtl/gain_ramp_controller.sv - click-free gain sequencer for the stereo volume multiplier
//
// Purpose : maps switch code and mute to a target gain and slews the output gain
//           toward it by at most RAMP_STEP per completed stereo packet.
// Ports   : clk         - system clock
//           resetn      - asynchronous active-low reset (gain forced to 0)
//           sw          - asynchronous volume code
//           mute        - asynchronous mute level
//           pkt_last_hs - one-cycle pulse per completed stereo packet
//           gain        - gain word latched by the multiplier
//           gain_update - pulses in the cycle gain holds a new value
//           ramp_active - gain has not yet reached the effective target
//           muted       - mute in effect and gain has reached 0
module gain_ramp_controller
  import vol_ctrl_pkg::*;
#(
  parameter int                    SWITCH_WIDTH = 4,
  parameter int                    GAIN_WIDTH   = 25,
  parameter logic [GAIN_WIDTH-1:0] RAMP_STEP    = 25'h0010000,
  parameter int                    SYNC_STAGES  = 3
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [SWITCH_WIDTH-1:0] sw,
  input  logic                    mute,
  input  logic                    pkt_last_hs,
  output logic [GAIN_WIDTH-1:0]   gain,
  output logic                    gain_update,
  output logic                    ramp_active,
  output logic                    muted
);

  logic [SWITCH_WIDTH-1:0] w_sw_sync;
  logic                    w_mute_sync;

  logic [GAIN_WIDTH-1:0]   r_target;
  logic [GAIN_WIDTH-1:0]   r_gain;
  logic                    r_gain_update;
  state_t                  r_state;
  logic                    r_ramp_active;
  logic                    r_muted;

  logic [GAIN_WIDTH-1:0]   w_eff_tgt;
  logic [GAIN_WIDTH:0]     w_diff_up;
  logic [GAIN_WIDTH:0]     w_diff_dn;
  logic                    w_up;
  logic                    w_close;
  logic [GAIN_WIDTH-1:0]   w_next_gain;
  logic                    w_at_tgt;
  logic                    w_zero_muted;

  sync_bus #(
    .WIDTH (SWITCH_WIDTH),
    .DEPTH (SYNC_STAGES)
  ) u_sw_sync (
    .clk    (clk),
    .resetn (resetn),
    .i_data (sw),
    .o_data (w_sw_sync)
  );

  sync_bus #(
    .WIDTH (1),
    .DEPTH (SYNC_STAGES)
  ) u_mute_sync (
    .clk    (clk),
    .resetn (resetn),
    .i_data (mute),
    .o_data (w_mute_sync)
  );

  // Registering the table lookup adds the fourth cycle of input latency.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_target <= '0;
    end else begin
      r_target <= GAIN_WIDTH'(gain_table(w_sw_sync));
    end
  end

  assign w_eff_tgt = w_mute_sync ? '0 : r_target;

  // One extra bit keeps both differences and the step compare free of wrap.
  assign w_up      = (w_eff_tgt > r_gain);
  assign w_diff_up = {1'b0, w_eff_tgt} - {1'b0, r_gain};
  assign w_diff_dn = {1'b0, r_gain} - {1'b0, w_eff_tgt};
  assign w_close   = w_up ? (w_diff_up <= {1'b0, RAMP_STEP})
                          : (w_diff_dn <= {1'b0, RAMP_STEP});

  always_comb begin
    w_next_gain = r_gain;
    if (w_close) begin
      w_next_gain = w_eff_tgt;
    end else if (w_up) begin
      w_next_gain = r_gain + RAMP_STEP;
    end else begin
      w_next_gain = r_gain - RAMP_STEP;
    end
  end

  // Gain only moves on packet completion so left and right of a packet always
  // share the same multiplier value.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_gain        <= '0;
      r_gain_update <= 1'b0;
    end else if (pkt_last_hs) begin
      r_gain        <= w_next_gain;
      r_gain_update <= (w_next_gain != r_gain);
    end else begin
      r_gain_update <= 1'b0;
    end
  end

  assign w_at_tgt     = (r_gain == w_eff_tgt);
  assign w_zero_muted = w_mute_sync && (r_gain == '0);

  // Status outputs are registered alongside the state so they track it exactly.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state       <= S_RAMP;
      r_ramp_active <= 1'b0;
      r_muted       <= 1'b0;
    end else begin
      case (r_state)
        S_HOLD: begin
          // Mute with a zero table entry lands here already at 0.
          if (w_zero_muted) begin
            r_state       <= S_MUTED;
            r_ramp_active <= 1'b0;
            r_muted       <= 1'b1;
          end else if (!w_at_tgt) begin
            r_state       <= S_RAMP;
            r_ramp_active <= 1'b1;
            r_muted       <= 1'b0;
          end else begin
            r_ramp_active <= 1'b0;
            r_muted       <= 1'b0;
          end
        end
        S_RAMP: begin
          if (w_zero_muted) begin
            r_state       <= S_MUTED;
            r_ramp_active <= 1'b0;
            r_muted       <= 1'b1;
          end else if (w_at_tgt) begin
            r_state       <= S_HOLD;
            r_ramp_active <= 1'b0;
            r_muted       <= 1'b0;
          end else begin
            r_ramp_active <= 1'b1;
            r_muted       <= 1'b0;
          end
        end
        S_MUTED: begin
          if (!w_mute_sync) begin
            if (r_target != '0) begin
              r_state       <= S_RAMP;
              r_ramp_active <= 1'b1;
              r_muted       <= 1'b0;
            end else begin
              r_state       <= S_HOLD;
              r_ramp_active <= 1'b0;
              r_muted       <= 1'b0;
            end
          end else begin
            r_ramp_active <= 1'b0;
            r_muted       <= 1'b1;
          end
        end
        default: begin
          r_state       <= S_RAMP;
          r_ramp_active <= 1'b0;
          r_muted       <= 1'b0;
        end
      endcase
    end
  end

  assign gain        = r_gain;
  assign gain_update = r_gain_update;
  assign ramp_active = r_ramp_active;
  assign muted       = r_muted;

endmodule

// File: tb/tb_gain_ramp_controller.sv
// tb/tb_gain_ramp_controller.sv - self-checking bench for gain_ramp_controller
module tb_gain_ramp_controller;

  localparam int STEP = 32'h10000;
  localparam int ONE  = 32'h1000000;

  logic        clk;
  logic        resetn;
  logic [3:0]  sw;
  logic        mute;
  logic        pkt_last_hs;
  logic [24:0] gain;
  logic        gain_update;
  logic        ramp_active;
  logic        muted;

  int checks;
  int errors;
  int upd_cnt;

  // Reference model state, in plain integers.
  int m_gain;
  int m_target;
  bit m_upd;
  bit m_ramp;
  bit m_muted;
  int sw_h[$];
  int mute_h[$];

  gain_ramp_controller dut (
    .clk         (clk),
    .resetn      (resetn),
    .sw          (sw),
    .mute        (mute),
    .pkt_last_hs (pkt_last_hs),
    .gain        (gain),
    .gain_update (gain_update),
    .ramp_active (ramp_active),
    .muted       (muted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int tbl(input int n);
    return (n == 15) ? ONE : n * 32'h111111;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_gain   = 0;
    m_target = 0;
    m_upd    = 0;
    m_ramp   = 0;
    m_muted  = 0;
    sw_h     = '{0, 0, 0};
    mute_h   = '{0, 0, 0};
  endtask

  task automatic check_all();
    chk("gain", 32'(gain), 32'(m_gain));
    chk("gain_update", 32'(gain_update), 32'(m_upd));
    chk("ramp_active", 32'(ramp_active), 32'(m_ramp));
    chk("muted", 32'(muted), 32'(m_muted));
    if (gain_update) upd_cnt++;
  endtask

  // One clock: status reflects the previous cycle's gain vs effective target,
  // gain slews toward the old effective target, inputs reach target 4 cycles on.
  task automatic tick(input logic pkt);
    int eff;
    int d;
    int ng;
    pkt_last_hs = pkt;
    @(posedge clk);
    eff     = (mute_h[0] != 0) ? 0 : m_target;
    m_muted = (mute_h[0] != 0) && (m_gain == 0);
    m_ramp  = !m_muted && (m_gain != eff);
    if (pkt) begin
      d = eff - m_gain;
      if (d <= STEP && d >= -STEP) ng = eff;
      else if (d > 0)              ng = m_gain + STEP;
      else                         ng = m_gain - STEP;
      m_upd  = (ng != m_gain);
      m_gain = ng;
    end else begin
      m_upd = 0;
    end
    m_target = tbl(sw_h[0]);
    void'(sw_h.pop_front());
    sw_h.push_back(int'(sw));
    void'(mute_h.pop_front());
    mute_h.push_back(int'(mute));
    #1;
    check_all();
    pkt_last_hs = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0);
  endtask

  task automatic packet();
    idle(3);
    tick(1'b1);
  endtask

  task automatic apply_reset();
    resetn = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all();
    resetn = 1'b1;
  endtask

  initial begin
    int prev;
    int v;
    checks      = 0;
    errors      = 0;
    upd_cnt     = 0;
    sw          = 4'd15;
    mute        = 1'b0;
    pkt_last_hs = 1'b0;

    // Soft start to unity.
    apply_reset();
    idle(8);
    upd_cnt = 0;
    for (int p = 0; p < 300; p++) begin
      packet();
      if (p == 254) chk("gain_at_255", 32'(gain), 32'hFF0000);
      if (p == 255) chk("gain_at_256", 32'(gain), 32'(ONE));
    end
    chk("upd_count_256", 32'(upd_cnt), 32'd256);
    chk("ramp_done", 32'(ramp_active), 32'd0);

    // Down to code 8; last step is the remainder.
    sw = 4'd8;
    idle(8);
    prev = 0;
    for (int p = 0; p < 120; p++) begin
      prev = int'(gain);
      packet();
    end
    chk("gain_sw8", 32'(gain), 32'h888888);
    chk("last_step", 32'(prev - int'(gain)), 32'h7778);

    // Mute ramps to zero in 137 packets; muted follows a cycle later.
    mute = 1'b1;
    idle(8);
    for (int p = 0; p < 137; p++) packet();
    chk("gain_muted_zero", 32'(gain), 32'd0);
    chk("muted_lag", 32'(muted), 32'd0);
    tick(1'b0);
    chk("muted_set", 32'(muted), 32'd1);

    // Unmute returns to code 8 target.
    mute = 1'b0;
    idle(8);
    for (int p = 0; p < 137; p++) packet();
    chk("gain_unmute", 32'(gain), 32'h888888);

    // Switch churn without packets leaves gain frozen.
    for (int i = 0; i < 1000; i++) begin
      v = $urandom_range(0, 14);
      if (v >= 8) v++;
      sw = 4'(v);
      tick(1'b0);
    end
    idle(6);
    chk("frozen_gain", 32'(gain), 32'h888888);
    chk("frozen_ramp", 32'(ramp_active), 32'd1);

    // Random traffic, consecutive packets allowed.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) sw = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 199) == 0) mute = ~mute;
      tick(($urandom_range(0, 2) == 0) ? 1'b1 : 1'b0);
    end
    mute = 1'b0;
    sw   = 4'd0;
    for (int i = 0; i < 300; i++) tick(1'b1);
    chk("sw0_gain", 32'(gain), 32'd0);
    chk("sw0_not_muted", 32'(muted), 32'd0);
    chk("sw0_hold", 32'(ramp_active), 32'd0);

    // Asynchronous reset mid-ramp at 0x400000.
    sw = 4'd15;
    apply_reset();
    idle(8);
    for (int p = 0; p < 64; p++) packet();
    chk("pre_reset_gain", 32'(gain), 32'h400000);
    #2;
    resetn = 1'b0;
    #1;
    chk("async_gain", 32'(gain), 32'd0);
    chk("async_update", 32'(gain_update), 32'd0);
    chk("async_ramp", 32'(ramp_active), 32'd0);
    chk("async_muted", 32'(muted), 32'd0);
    apply_reset();
    idle(10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
